control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
Multicycle control FSM for the 32-bit stack-assisted RISC core.
- Holds the instruction-phase state register.
- Decodes inst_type/inst_function together with stop_bit and zero_flag.
- Drives every datapath select, write enable and the ALU opcode.
- Exposes next_state so the datapath loads the PC exactly when next_state returns to IF.

Parameters:
none (all encodings fixed below)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
inst_type  input  2  00 R-type, 01 J-type, 10 I-type, 11 S-type
inst_function  input  5  function code within type
stop_bit  input  1  instruction's stop bit; 1 means pop return address on completion
zero_flag  input  1  ALU zero result from the EX cycle
ExSrc  output  1  extender source: 0 = 16-bit immediate, 1 = 5-bit shift amount
ExS  output  1  extension mode: 1 = sign, 0 = zero
RS2src  output  1  second register read address: 0 = Rs2 field, 1 = Rd field
WB  output  1  register-file write enable
MemR  output  1  data-memory read
MemW  output  1  data-memory write
WBdata  output  1  write-back data: 0 = ALU, 1 = memory
PCsrc  output  1  next PC: 0 = PC adder, 1 = stack top
PCaddSrc1  output  1  adder operand A: 0 = PC, 1 = zero
PCaddSrc2  output  1  adder operand B: 0 = constant 1, 1 = extended offset
ALUsrc  output  1  ALU operand B: 0 = register, 1 = extended immediate
StR  output  1  stack pop
StW  output  1  stack push (PC+1)
ALUop  output  4  0 AND, 1 ADD, 2 SUB, 3 SLL, 4 SRL; others unused
next_state  output  3  combinational next value of the state register

Behaviour:
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4. States 5–7 are illegal: next_state=IF, all enables 0.
- rst_n low, asynchronous: state=IF immediately. While rst_n is low, next_state=IF and all outputs are 0.
- Release is synchronous in effect: the first rising edge after rst_n goes high moves IF→ID.
- All outputs are combinational from state and inputs. The state register updates on the rising clk edge.
- Decode table (type:function):
  - R: 0 AND, 1 ADD, 2 SUB, 3 CMP (SUB, WB).
  - I: 0 ANDI (zero-ext), 1 ADDI, 2 LW, 3 SW, 4 BEQ (sign-ext).
  - J: 0 J, 1 JAL.
  - S: 0 SLL, 1 SRL (shamt from ExSrc=1), 2 SLLV, 3 SRLV (register amount).
  - Any other code is a NOP: IF→ID→IF, no enables.
- Transitions:
  - IF→ID always.
  - ID→IF for J, JAL and NOP.
  - ID→EX for all others.
  - EX→WB for R, S, ANDI, ADDI.
  - EX→MEM for LW, SW.
  - EX→IF for BEQ.
  - MEM→WB for LW; MEM→IF for SW.
  - WB→IF.
- Select outputs (ExSrc, ExS, RS2src, ALUsrc, ALUop, WBdata) are held at their decoded values in ID, EX, MEM and WB. They are 0 in IF.
- Enables are single-cycle:
  - WB only in the WB state.
  - MemR only in MEM for LW; MemW only in MEM for SW.
  - StW only in ID for JAL.
- SW and BEQ use RS2src=1.
- PC selects are meaningful only in an instruction's final state (the cycle where next_state=IF); otherwise they are 0, which selects PC+1.
  - J/JAL in ID: PCaddSrc2=1, PCaddSrc1=0, giving PC+offset.
  - BEQ in EX with zero_flag=1: PCaddSrc2=1. With zero_flag=0: PC+1.
- stop_bit=1 in the final state of a non-J, non-taken-branch instruction: StR=1, PCsrc=1.
- J-type and taken BEQ ignore stop_bit: no pop.
- SW with stop_bit: MemW and StR are asserted in the same MEM cycle.
- inst_function bit 4 is ignored for decode (functions 16–31 alias 0–15).

Test Plan:
1. rst_n=0 mid-EX of ADD → state=IF at once, next_state=0, all outputs 0. Release → ID on the first edge, then EX.
2. R ADD (00, func 1), stop_bit=0 → states 0,1,2,4,0. ALUop=1. WB=1 only in state 4. PCsrc=0.
3. I LW (10, func 2) → states 0,1,2,3,4,0. MemR=1 in 3. WB=1 and WBdata=1 in 4. ALUsrc=1, ExS=1.
4. BEQ (10, func 4) with zero_flag=1 → EX: ALUop=2, RS2src=1, PCaddSrc2=1, next_state=0. With zero_flag=0 → PCaddSrc2=0.
5. JAL (01, func 1) → ID: StW=1, PCaddSrc2=1, next_state=0. stop_bit=1 gives StR=0.
6. ADDI with stop_bit=1 → WB state: WB=1, StR=1, PCsrc=1. Undefined function 9 of R-type → IF→ID→IF, no enables.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: multicycle control FSM for the stack-assisted RISC core.
// Outputs are decoded combinationally from the phase register and inputs.
module control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] inst_type,
  input  logic [4:0] inst_function,
  input  logic       stop_bit,
  input  logic       zero_flag,
  output logic       ExSrc,
  output logic       ExS,
  output logic       RS2src,
  output logic       WB,
  output logic       MemR,
  output logic       MemW,
  output logic       WBdata,
  output logic       PCsrc,
  output logic       PCaddSrc1,
  output logic       PCaddSrc2,
  output logic       ALUsrc,
  output logic       StR,
  output logic       StW,
  output logic [3:0] ALUop,
  output logic [2:0] next_state
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t state;
  state_t nxt;

  logic [3:0] fn;
  logic       unused_fn;
  assign fn        = inst_function[3:0];
  assign unused_fn = inst_function[4];

  logic       is_j, is_jal, is_lw, is_sw, is_beq, is_nop;
  logic       d_exsrc, d_exs, d_rs2, d_alusrc, d_wbdata;
  logic [3:0] d_aluop;

  always_comb begin
    is_j     = 1'b0;
    is_jal   = 1'b0;
    is_lw    = 1'b0;
    is_sw    = 1'b0;
    is_beq   = 1'b0;
    is_nop   = 1'b0;
    d_exsrc  = 1'b0;
    d_exs    = 1'b0;
    d_rs2    = 1'b0;
    d_alusrc = 1'b0;
    d_wbdata = 1'b0;
    d_aluop  = 4'd0;
    unique case (inst_type)
      2'b00: begin
        unique case (fn)
          4'd0:       d_aluop = 4'd0;
          4'd1:       d_aluop = 4'd1;
          4'd2, 4'd3: d_aluop = 4'd2;
          default:    is_nop  = 1'b1;
        endcase
      end
      2'b01: begin
        // J-type offsets are signed PC-relative displacements
        unique case (fn)
          4'd0: begin
            is_j  = 1'b1;
            d_exs = 1'b1;
          end
          4'd1: begin
            is_j   = 1'b1;
            is_jal = 1'b1;
            d_exs  = 1'b1;
          end
          default: is_nop = 1'b1;
        endcase
      end
      2'b10: begin
        unique case (fn)
          4'd0: d_alusrc = 1'b1;
          4'd1: begin
            d_alusrc = 1'b1;
            d_exs    = 1'b1;
            d_aluop  = 4'd1;
          end
          4'd2: begin
            is_lw    = 1'b1;
            d_alusrc = 1'b1;
            d_exs    = 1'b1;
            d_wbdata = 1'b1;
            d_aluop  = 4'd1;
          end
          4'd3: begin
            is_sw    = 1'b1;
            d_alusrc = 1'b1;
            d_exs    = 1'b1;
            d_rs2    = 1'b1;
            d_aluop  = 4'd1;
          end
          4'd4: begin
            is_beq  = 1'b1;
            d_exs   = 1'b1;
            d_rs2   = 1'b1;
            d_aluop = 4'd2;
          end
          default: is_nop = 1'b1;
        endcase
      end
      2'b11: begin
        unique case (fn)
          4'd0: begin
            d_exsrc  = 1'b1;
            d_alusrc = 1'b1;
            d_aluop  = 4'd3;
          end
          4'd1: begin
            d_exsrc  = 1'b1;
            d_alusrc = 1'b1;
            d_aluop  = 4'd4;
          end
          4'd2:    d_aluop = 4'd3;
          4'd3:    d_aluop = 4'd4;
          default: is_nop  = 1'b1;
        endcase
      end
      default: is_nop = 1'b1;
    endcase
  end

  always_comb begin
    nxt = S_IF;
    case (state)
      S_IF:  nxt = S_ID;
      S_ID:  nxt = (is_j || is_nop) ? S_IF : S_EX;
      S_EX: begin
        if (is_lw || is_sw) nxt = S_MEM;
        else if (is_beq)    nxt = S_IF;
        else                nxt = S_WB;
      end
      S_MEM: nxt = is_lw ? S_WB : S_IF;
      S_WB:  nxt = S_IF;
      default: nxt = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IF;
    else        state <= nxt;
  end

  logic live, fin, taken, pop;

  // live: a legal post-fetch phase; fin: last phase of the instruction
  assign live  = rst_n && (state != S_IF) && (state <= S_WB);
  assign fin   = live && (nxt == S_IF);
  assign taken = is_beq && (state == S_EX) && zero_flag;
  assign pop   = fin && stop_bit && !is_j && !is_nop && !taken;

  assign ExSrc  = live && d_exsrc;
  assign ExS    = live && d_exs;
  assign RS2src = live && d_rs2;
  assign ALUsrc = live && d_alusrc;
  assign WBdata = live && d_wbdata;
  assign ALUop  = live ? d_aluop : 4'd0;

  assign WB   = live && (state == S_WB);
  assign MemR = live && (state == S_MEM) && is_lw;
  assign MemW = live && (state == S_MEM) && is_sw;
  assign StW  = live && (state == S_ID) && is_jal;

  assign PCaddSrc1 = 1'b0;
  assign PCaddSrc2 = fin && (is_j || taken);
  assign PCsrc     = pop;
  assign StR       = pop;

  assign next_state = rst_n ? nxt : S_IF;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed and random checks of control_unit
// against a path-based reference model.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] inst_type;
  logic [4:0] inst_function;
  logic       stop_bit;
  logic       zero_flag;
  logic       ExSrc, ExS, RS2src, WB, MemR, MemW, WBdata, PCsrc;
  logic       PCaddSrc1, PCaddSrc2, ALUsrc, StR, StW;
  logic [3:0] ALUop;
  logic [2:0] next_state;

  control_unit dut (
    .clk(clk), .rst_n(rst_n),
    .inst_type(inst_type), .inst_function(inst_function),
    .stop_bit(stop_bit), .zero_flag(zero_flag),
    .ExSrc(ExSrc), .ExS(ExS), .RS2src(RS2src), .WB(WB),
    .MemR(MemR), .MemW(MemW), .WBdata(WBdata), .PCsrc(PCsrc),
    .PCaddSrc1(PCaddSrc1), .PCaddSrc2(PCaddSrc2), .ALUsrc(ALUsrc),
    .StR(StR), .StW(StW), .ALUop(ALUop), .next_state(next_state)
  );

  always #5 clk = ~clk;

  localparam int C_ALU = 0, C_LW = 1, C_SW = 2, C_BEQ = 3;
  localparam int C_J = 4, C_JAL = 5, C_NOP = 6;

  typedef struct packed {
    logic [2:0] c;
    logic [3:0] op;
    logic       asrc;
    logic       esrc;
    logic       es;
    logic       rs2;
    logic       wbd;
  } dec_t;

  int   ncmp = 0;
  int   nbad = 0;
  dec_t d;
  int   path [5];
  int   plen;
  int   pos;
  logic [19:0] cap [5];

  function automatic dec_t mk(int c, int op, bit asrc, bit esrc,
                              bit es, bit rs2, bit wbd);
    dec_t r;
    r.c = 3'(c); r.op = 4'(op); r.asrc = asrc; r.esrc = esrc;
    r.es = es; r.rs2 = rs2; r.wbd = wbd;
    return r;
  endfunction

  // instruction table: class, ALU op, and the select values
  function automatic dec_t decode(logic [1:0] t, logic [4:0] f);
    int g;
    dec_t r;
    g = int'(f) % 16;
    r = mk(C_NOP, 0, 0, 0, 0, 0, 0);
    case (t)
      2'd0: if (g <= 3) r = mk(C_ALU, (g == 0) ? 0 : (g == 1) ? 1 : 2,
                               0, 0, 0, 0, 0);
      2'd1: if (g <= 1) r = mk((g == 0) ? C_J : C_JAL, 0, 0, 0, 1, 0, 0);
      2'd2: case (g)
        0: r = mk(C_ALU, 0, 1, 0, 0, 0, 0);
        1: r = mk(C_ALU, 1, 1, 0, 1, 0, 0);
        2: r = mk(C_LW,  1, 1, 0, 1, 0, 1);
        3: r = mk(C_SW,  1, 1, 0, 1, 1, 0);
        4: r = mk(C_BEQ, 2, 0, 0, 1, 1, 0);
        default: ;
      endcase
      default: if (g <= 3) r = mk(C_ALU, (g % 2 == 0) ? 3 : 4,
                                  g < 2, g < 2, 0, 0, 0);
    endcase
    return r;
  endfunction

  function automatic void load();
    d = decode(inst_type, inst_function);
    case (int'(d.c))
      C_ALU: begin path = '{0, 1, 2, 4, 0}; plen = 4; end
      C_LW:  begin path = '{0, 1, 2, 3, 4}; plen = 5; end
      C_SW:  begin path = '{0, 1, 2, 3, 0}; plen = 4; end
      C_BEQ: begin path = '{0, 1, 2, 0, 0}; plen = 3; end
      default: begin path = '{0, 1, 0, 0, 0}; plen = 2; end
    endcase
  endfunction

  function automatic logic [19:0] outv();
    return {ExSrc, ExS, RS2src, WB, MemR, MemW, WBdata, PCsrc,
            PCaddSrc1, PCaddSrc2, ALUsrc, StR, StW, ALUop, next_state};
  endfunction

  task automatic cmp();
    logic [19:0] e, a;
    int ph, nx;
    bit last, jt, tk, pop;
    a = outv();
    e = '0;
    if (rst_n) begin
      ph   = path[pos];
      last = (pos == plen - 1);
      nx   = last ? 0 : path[pos + 1];
      if (ph != 0) begin
        e[19] = d.esrc; e[18] = d.es; e[17] = d.rs2;
        e[13] = d.wbd;  e[9] = d.asrc; e[6:3] = d.op;
      end
      e[16] = (ph == 4);
      e[15] = (ph == 3) && (int'(d.c) == C_LW);
      e[14] = (ph == 3) && (int'(d.c) == C_SW);
      e[7]  = (ph == 1) && (int'(d.c) == C_JAL);
      jt    = (int'(d.c) == C_J) || (int'(d.c) == C_JAL);
      tk    = (int'(d.c) == C_BEQ) && (ph == 2) && zero_flag;
      e[10] = last && (jt || tk);
      pop   = last && stop_bit && !jt && !tk && (int'(d.c) != C_NOP);
      e[12] = pop;
      e[8]  = pop;
      e[2:0] = 3'(nx);
    end
    ncmp++;
    if (a !== e) begin
      nbad++;
      $display("FAIL model t=%0t type=%0d fn=%0d phase_idx=%0d: got %05h want %05h",
               $time, inst_type, inst_function, pos, a, e);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    if (!rst_n) pos = 0;
    else pos = (pos == plen - 1) ? 0 : pos + 1;
    #1;
  endtask

  task automatic run(input logic [1:0] t, input logic [4:0] f,
                     input logic s, input logic z);
    inst_type = t; inst_function = f; stop_bit = s; zero_flag = z;
    load();
    for (int k = 0; k < 5; k++) cap[k] = '0;
    for (int k = 0; k < plen; k++) begin
      @(negedge clk);
      cap[k] = outv();
      cmp();
      adv();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    rst_n = 1'b0; inst_type = 2'd0; inst_function = 5'd1;
    stop_bit = 1'b0; zero_flag = 1'b0;
    load(); pos = 0;
    #3;
    cmp();
    lit("rst_outputs", 32'(outv()), 0);
    @(posedge clk); #1;
    cmp();
    rst_n = 1'b1;

    run(2'b00, 5'd1, 1'b0, 1'b0);
    lit("add_ns_if", 32'(cap[0][2:0]), 0 + 1);
    lit("add_ns_id", 32'(cap[1][2:0]), 2);
    lit("add_ns_ex", 32'(cap[2][2:0]), 4);
    lit("add_ns_wb", 32'(cap[3][2:0]), 0);
    lit("add_aluop", 32'(cap[2][6:3]), 1);
    lit("add_wb_ex", 32'(cap[2][16]), 0);
    lit("add_wb_wb", 32'(cap[3][16]), 1);
    lit("add_pcsrc", 32'(cap[3][12]), 0);

    run(2'b10, 5'd2, 1'b0, 1'b0);
    lit("lw_ns_mem", 32'(cap[3][2:0]), 4);
    lit("lw_memr", 32'(cap[3][15]), 1);
    lit("lw_wb", 32'(cap[4][16]), 1);
    lit("lw_wbdata", 32'(cap[4][13]), 1);
    lit("lw_alusrc", 32'(cap[2][9]), 1);
    lit("lw_exs", 32'(cap[2][18]), 1);

    run(2'b10, 5'd4, 1'b0, 1'b1);
    lit("beq_aluop", 32'(cap[2][6:3]), 2);
    lit("beq_rs2src", 32'(cap[2][17]), 1);
    lit("beq_taken_pc2", 32'(cap[2][10]), 1);
    lit("beq_ns", 32'(cap[2][2:0]), 0);
    run(2'b10, 5'd4, 1'b0, 1'b0);
    lit("beq_nt_pc2", 32'(cap[2][10]), 0);
    run(2'b10, 5'd4, 1'b1, 1'b1);
    lit("beq_taken_str", 32'(cap[2][8]), 0);

    run(2'b01, 5'd1, 1'b1, 1'b0);
    lit("jal_stw", 32'(cap[1][7]), 1);
    lit("jal_pc2", 32'(cap[1][10]), 1);
    lit("jal_ns", 32'(cap[1][2:0]), 0);
    lit("jal_str", 32'(cap[1][8]), 0);

    run(2'b10, 5'd1, 1'b1, 1'b0);
    lit("addi_wb", 32'(cap[3][16]), 1);
    lit("addi_str", 32'(cap[3][8]), 1);
    lit("addi_pcsrc", 32'(cap[3][12]), 1);

    run(2'b00, 5'd9, 1'b1, 1'b0);
    lit("nop_ns", 32'(cap[1][2:0]), 0);
    lit("nop_quiet", 32'(cap[1][19:3]), 0);

    run(2'b10, 5'd3, 1'b1, 1'b0);
    lit("sw_memw", 32'(cap[3][14]), 1);
    lit("sw_str", 32'(cap[3][8]), 1);

    run(2'b00, 5'd17, 1'b0, 1'b0);
    lit("alias_aluop", 32'(cap[2][6:3]), 1);
    run(2'b11, 5'd0, 1'b0, 1'b0);
    lit("sll_exsrc", 32'(cap[2][19]), 1);
    lit("sll_aluop", 32'(cap[2][6:3]), 3);

    // asynchronous reset in the middle of an ADD's EX phase
    inst_type = 2'b00; inst_function = 5'd1; stop_bit = 1'b0;
    zero_flag = 1'b0; load();
    @(negedge clk); cmp(); adv();
    @(negedge clk); cmp(); adv();
    @(negedge clk); cmp();
    lit("rst_pre_ns", 32'(next_state), 4);
    #2 rst_n = 1'b0;
    #1 cmp();
    lit("rst_async_out", 32'(outv()), 0);
    adv();
    @(negedge clk); cmp();
    #1 rst_n = 1'b1;
    #1 cmp();
    lit("rst_rel_ns", 32'(next_state), 1);
    adv();
    @(negedge clk); cmp();
    lit("rst_id_ns", 32'(next_state), 2);
    adv();
    @(negedge clk); cmp(); adv();
    @(negedge clk); cmp(); adv();

    repeat (800) begin
      if (pos == 0) begin
        inst_type = 2'($urandom_range(0, 3));
        v = $urandom_range(0, 7);
        if ($urandom_range(0, 3) == 0) v = $urandom_range(8, 15);
        if ($urandom_range(0, 1) == 1) v += 16;
        inst_function = 5'(v);
        stop_bit = 1'($urandom_range(0, 1));
        load();
      end
      zero_flag = 1'($urandom_range(0, 1));
      @(negedge clk);
      cmp();
      adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
